// File: rtl/shiftreg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shiftreg_seq_ctrl
//   Sequencer for a DEPTH-stage serial shift-register chain. The chain takes
//   its data in at stage 0. A parallel word is accepted over a valid/ready
//   handshake. Its LEN used bits are then sent MSB first on ser_out, and a
//   one-cycle shift_en strobe is raised once every DIV clocks. When FLUSH is
//   set, DEPTH zero bits follow the data so that the last data bit reaches
//   the chain output. done pulses for one cycle at the end of the transfer.
//
// Ports
//   clk         : system clock, rising edge
//   clr         : synchronous active-high reset
//   start_valid : request to send data_in/len
//   start_ready : controller idle; the request is accepted this cycle if valid
//   data_in     : word to serialise; bits [len-1:0] are used
//   len         : bit count; 0 or a value greater than WIDTH means WIDTH
//   ser_out     : serial data to the chain input
//   shift_en    : one-cycle strobe; the chain shifts while it is high
//   busy        : high from the cycle after accept through the done cycle
//   done        : one-cycle pulse marking transfer completion
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module shiftreg_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int DIV   = 1,
  parameter int FLUSH = 1
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [$clog2(WIDTH+1)-1:0]   len,
  output logic                         ser_out,
  output logic                         shift_en,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] FLUSH_N   = (FLUSH != 0) ? CW'(DEPTH) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     bit_q,   bit_d;
  logic [CW-1:0]     n_q,     n_d;
  logic [WIDTH-1:0]  hold_q,  hold_d;
  logic              ready_q, ready_d;
  logic              ser_q,   ser_d;
  logic              shift_q, shift_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [LW-1:0]     l_eff;
  logic [LW-1:0]     shamt;
  logic              accept;

  // Out-of-range lengths collapse to a full word. The word is left-aligned
  // in the holding register so that its MSB is always at the top bit. Each
  // shift then pulls in a zero, which provides the flush bits with no extra
  // logic.
  assign l_eff  = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;
  assign shamt  = LW'(WIDTH) - l_eff;
  assign accept = start_valid && ready_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      bit_q   <= '0;
      n_q     <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      ser_q   <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      n_q     <= n_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      ser_q   <= ser_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bit_d   = bit_q;
    n_d     = n_q;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          presc_d = '0;
          bit_d   = '0;
          hold_d  = data_in << shamt;
          n_d     = CW'(l_eff) + FLUSH_N;
        end
      end
      S_SHIFT: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          hold_d  = hold_q << 1;
          if (bit_q == n_q - CW'(1)) begin
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The outputs are computed from the next state so that the registered
    // outputs line up with the state they describe.
    ser_d   = (state_d == S_SHIFT) && hold_d[WIDTH-1];
    shift_d = (state_d == S_SHIFT) && (presc_d == PRESC_MAX);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  assign start_ready = ready_q;
  assign ser_out     = ser_q;
  assign shift_en    = shift_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
module tb_shiftreg_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       sv;
  logic [3:0] din;
  logic [2:0] ln;
  logic       sel;

  logic rdy1, ser1, sh1, busy1, done1;
  logic rdy3, ser3, sh3, busy3, done3;
  logic o_rdy, o_ser, o_sh, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] chain;

  always #5 clk = ~clk;

  shiftreg_seq_ctrl #(.WIDTH(4), .DEPTH(4), .DIV(1), .FLUSH(1)) dut1 (
    .clk(clk), .clr(clr), .start_valid(sv), .start_ready(rdy1),
    .data_in(din), .len(ln), .ser_out(ser1), .shift_en(sh1),
    .busy(busy1), .done(done1));

  shiftreg_seq_ctrl #(.WIDTH(4), .DEPTH(4), .DIV(3), .FLUSH(1)) dut3 (
    .clk(clk), .clr(clr), .start_valid(sv), .start_ready(rdy3),
    .data_in(din), .len(ln), .ser_out(ser3), .shift_en(sh3),
    .busy(busy3), .done(done3));

  assign o_rdy  = sel ? rdy3  : rdy1;
  assign o_ser  = sel ? ser3  : ser1;
  assign o_sh   = sel ? sh3   : sh1;
  assign o_busy = sel ? busy3 : busy1;
  assign o_done = sel ? done3 : done1;

  // The external 4-stage chain driven by the DIV=1 instance; E = chain[3].
  always @(posedge clk) begin
    if (sh1) chain <= {chain[2:0], ser1};
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the serial stream is the used bits MSB first followed by
  // DEPTH zeros; the stream is left-aligned in s.
  function automatic void model(input logic [3:0] d, input logic [2:0] l,
                                output logic [7:0] s, output int n);
    int L;
    L = (l == 0 || l > 4) ? 4 : int'(l);
    s = '0;
    n = 0;
    for (int i = L - 1; i >= 0; i--) begin
      s[7-n] = d[i];
      n++;
    end
    n = n + 4;
  endfunction

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  // Runs one transfer and checks every cycle from accept to the return of
  // ready. With keep set, start_valid stays high carrying d2/l2 and the task
  // returns at the negedge of the ready cycle.
  task automatic do_xfer(input logic [3:0] d, input logic [2:0] l, input int div,
                         input logic [7:0] s, input int n, input bit keep,
                         input logic [3:0] d2, input logic [2:0] l2);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_rdy && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!o_rdy) begin
      errors++;
      $display("FAIL ready_wait: start_ready never rose within 60 cycles");
      return;
    end
    sv = 1'b1; din = d; ln = l;
    @(posedge clk);
    #1;
    if (keep) begin
      din = d2; ln = l2;
    end else begin
      sv = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < div; p++) begin
        @(negedge clk);
        chk("ser_out", o_ser, s[7-k]);
        chk("shift_en", o_sh, (p == div - 1) ? 1 : 0);
        chk("busy", o_busy, 1);
        chk("done_early", o_done, 0);
        chk("ready_busy", o_rdy, 0);
        if (!sel && k >= 4) chk("chain_E", chain[3], s[7-(k-4)]);
      end
    end
    @(negedge clk);
    chk("done", o_done, 1);
    chk("ser_done", o_ser, 0);
    chk("shift_done", o_sh, 0);
    chk("busy_done", o_busy, 1);
    chk("ready_done", o_rdy, 0);
    @(negedge clk);
    chk("ready_back", o_rdy, 1);
    chk("busy_idle", o_busy, 0);
    chk("done_once", o_done, 0);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [2:0] l;
    logic [7:0] s;
    int         n;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] s, s2;
    int n, n2, cnt, t;
    logic [3:0] rd, rd2;
    logic [2:0] rl, rl2;

    tbl[0] = '{4'b1011, 3'd4, 8'b1011_0000, 8};
    tbl[1] = '{4'b0010, 3'd2, 8'b1000_0000, 6};
    tbl[2] = '{4'b1011, 3'd0, 8'b1011_0000, 8};
    tbl[3] = '{4'b0110, 3'd5, 8'b0110_0000, 8};
    tbl[4] = '{4'b1111, 3'd1, 8'b1000_0000, 5};
    tbl[5] = '{4'b0101, 3'd3, 8'b1010_0000, 7};

    sel = 1'b0; sv = 1'b0; din = '0; ln = '0; clr = 1'b1;
    chain = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy1, 0); chk("rst_ser", ser1, 0); chk("rst_shift", sh1, 0);
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_ready3", rdy3, 0);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("ready_post_rst0", rdy1, 0);
    @(negedge clk);
    chk("ready_post_rst1", rdy1, 1);

    // Directed table, DIV=1
    for (int i = 0; i < 6; i++)
      do_xfer(tbl[i].d, tbl[i].l, 1, tbl[i].s, tbl[i].n, 1'b0, 4'h0, 3'd0);

    // start_valid held through a transfer; next word taken in first IDLE cycle
    model(4'b1001, 3'd4, s2, n2);
    do_xfer(4'b1101, 3'd4, 1, 8'b1101_0000, 8, 1'b1, 4'b1001, 3'd4);
    @(posedge clk); #1 sv = 1'b0;
    @(negedge clk);
    chk("b2b_busy", o_busy, 1);
    chk("b2b_ready", o_rdy, 0);
    chk("b2b_first_bit", o_ser, s2[7]);
    chk("b2b_shift", o_sh, 1);
    cnt = 1; t = 0;
    while (!o_done && t < 40) begin
      @(negedge clk);
      if (o_sh) cnt++;
      t++;
    end
    chk("b2b_done", o_done, 1);
    chk("b2b_strobes", cnt, n2);

    // Reset mid-transfer during cycle 4
    @(negedge clk);
    sv = 1'b1; din = 4'b1011; ln = 3'd4;
    @(posedge clk); #1 sv = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    chk("abort_busy_c4", o_busy, 1);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("abort_ser", o_ser, 0); chk("abort_shift", o_sh, 0);
    chk("abort_busy", o_busy, 0); chk("abort_done", o_done, 0);
    chk("abort_ready", o_rdy, 0);
    @(negedge clk);
    chk("abort_ready1", o_rdy, 1); chk("abort_nodone", o_done, 0);
    do_xfer(4'b1011, 3'd4, 1, 8'b1011_0000, 8, 1'b0, 4'h0, 3'd0);

    // Random, DIV=1
    for (int i = 0; i < 20; i++) begin
      rd = 4'($urandom); rl = 3'($urandom_range(0, 7));
      model(rd, rl, s, n);
      do_xfer(rd, rl, 1, s, n, 1'b0, 4'h0, 3'd0);
    end

    // DIV=3 instance
    sel = 1'b1;
    pulse_clr();
    do_xfer(4'b1000, 3'd4, 3, 8'b1000_0000, 8, 1'b0, 4'h0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      rd2 = 4'($urandom); rl2 = 3'($urandom_range(0, 7));
      model(rd2, rl2, s, n);
      do_xfer(rd2, rl2, 3, s, n, 1'b0, 4'h0, 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
